// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - word-addressed instruction memory with fixed-latency, in-order read responses
//
// Parameters:
//   DEPTH           memory size in 32-bit words (power of 2, >= 4)
//   LATENCY         cycles from read acceptance to o_mem_valid (>= 1)
//   MAX_OUTSTANDING accepted-but-unanswered reads allowed in flight (>= 1)
// Ports:
//   i_clk        single clock, rising edge
//   i_rst        synchronous active-high reset
//   i_mem_raddr  byte address for read or write (word index = raddr[log2(DEPTH)+1:2])
//   i_mem_ren    read request
//   i_mem_wen    write request (wins over a simultaneous read)
//   i_mem_wdata  write word
//   o_mem_ready  request accepted this cycle when high
//   o_mem_rdata  read response word, held while o_mem_valid is low
//   o_mem_valid  one-cycle pulse per accepted read
// Optional feature: define IMEM_RESP_STALL_EN to add a 16-bit LFSR that randomly
// withholds o_mem_ready.
module imem_responder #(
    parameter int DEPTH           = 1024,
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_mem_raddr,
    input  logic        i_mem_ren,
    input  logic        i_mem_wen,
    input  logic [31:0] i_mem_wdata,
    output logic        o_mem_ready,
    output logic [31:0] o_mem_rdata,
    output logic        o_mem_valid
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]        mem_q [DEPTH];
    logic [AW-1:0]      word_idx;
    logic               accept;
    logic               rd_acc;
    logic               wr_acc;
    logic               ready_base;
    logic               unused_addr_bits;

    // Response pipeline: stage 0 is loaded at acceptance, the last stage drives the outputs.
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [31:0]        dat_q [LATENCY];
    logic [31:0]        dat_d [LATENCY];
    logic [LATENCY:0]   chain_vld;
    logic [31:0]        chain_dat [LATENCY+1];

    logic [CW-1:0]      count_q, count_d;

    assign word_idx         = i_mem_raddr[AW+1:2];
    assign unused_addr_bits = ^{i_mem_raddr[31:AW+2], i_mem_raddr[1:0]};

    assign ready_base = !i_rst && (count_q < CW'(MAX_OUTSTANDING));

`ifdef IMEM_RESP_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    // Right-shifting Fibonacci form of taps 16,14,13,11.
    always_comb begin
        lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d  = {lfsr_fb, lfsr_q[15:1]};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_mem_ready = ready_base && !lfsr_q[0];
`else
    assign o_mem_ready = ready_base;
`endif

    assign accept = (i_mem_ren || i_mem_wen) && o_mem_ready;
    assign wr_acc = accept && i_mem_wen;
    assign rd_acc = accept && i_mem_ren && !i_mem_wen;

    always_comb begin
        // Entry i of the chain feeds pipeline stage i; entry 0 is the new read, whose word
        // is captured now so a later write cannot disturb it.
        chain_vld    = {vld_q, rd_acc};
        chain_dat[0] = mem_q[word_idx];
        for (int i = 0; i < LATENCY; i++) begin
            chain_dat[i+1] = dat_q[i];
        end

        vld_d = chain_vld[LATENCY-1:0];
        for (int i = 0; i < LATENCY; i++) begin
            // Data only moves with a valid token, so the last stage holds between pulses.
            dat_d[i] = chain_vld[i] ? chain_dat[i] : dat_q[i];
        end

        count_d = count_q;
        case ({rd_acc, o_mem_valid})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= 32'h0000_0000;
            end
        end else begin
            vld_q   <= vld_d;
            count_q <= count_d;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            mem_q[word_idx] <= i_mem_wdata;
        end
    end

    assign o_mem_valid = vld_q[LATENCY-1];
    assign o_mem_rdata = dat_q[LATENCY-1];
endmodule
